// File: rtl/kv_pkg.sv
// Shared encodings, hash constants and the cuckoo hash function for the
// key/value command sequencer.
package kv_pkg;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_CREDIT = 2'd2,
    OP_DEBIT  = 2'd3
  } kv_op_e;

  typedef enum logic [1:0] {
    SIG_SEARCH   = 2'd0,
    SIG_INSERT   = 2'd1,
    SIG_TRANSACT = 2'd2
  } kv_sig_e;

  typedef enum logic [1:0] {
    STAT_OK           = 2'd0,
    STAT_NOT_FOUND    = 2'd1,
    STAT_INSUFFICIENT = 2'd2,
    STAT_REJECTED     = 2'd3
  } kv_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HASH,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_ISSUE2,
    S_WAIT2,
    S_RESP
  } kv_state_e;

  localparam int unsigned H1_SLOTS = 11;
  localparam int unsigned H2_SLOTS = 22;
  localparam int unsigned H1_MULT  = 91;
  localparam int unsigned H2_MULT  = 45;
  localparam int unsigned HASH_MOD = 100;

  // floor(((key*mult) mod 100) * slots / 100), product truncated to 32 bits
  function automatic logic [31:0] kv_hash(input logic [31:0] key,
                                          input logic [31:0] mult,
                                          input logic [31:0] slots);
    logic [31:0] prod;
    logic [31:0] rem;
    prod = key * mult;
    rem  = prod % HASH_MOD;
    return (rem * slots) / HASH_MOD;
  endfunction

endpackage

// File: rtl/kv_hash_unit.sv
// Registered cuckoo hash stage: captures both table indices for a key when
// load is asserted and holds them until the next load.
module kv_hash_unit
  import kv_pkg::*;
#(
  parameter int KEY_WIDTH = 32,
  parameter int H_WIDTH   = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [KEY_WIDTH-1:0] key,
  output logic [H_WIDTH-1:0]   h1,
  output logic [H_WIDTH-1:0]   h2
);

  logic [31:0]        key32;
  logic [H_WIDTH-1:0] h1_q, h1_d;
  logic [H_WIDTH-1:0] h2_q, h2_d;

  // next index values: recompute only when a new key is loaded
  always_comb begin
    key32 = 32'(key);
    h1_d  = h1_q;
    h2_d  = h2_q;
    if (load) begin
      h1_d = H_WIDTH'(kv_hash(key32, H1_MULT, H1_SLOTS));
      h2_d = H_WIDTH'(kv_hash(key32, H2_MULT, H2_SLOTS));
    end
  end

  // index registers
  always_ff @(posedge clock) begin
    if (reset) begin
      h1_q <= '0;
      h2_q <= '0;
    end else begin
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end

  assign h1 = h1_q;
  assign h2 = h2_q;

endmodule

// File: rtl/kv_cmd_sequencer.sv
// Request FIFO plus single-command sequencer in front of the cuckoo-hash
// key/value store. Debits are split into a balance search and a subtract.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for a buffered request; pops the FIFO head
//   HASH   | hash indices settle; rejects insert of the empty-marker key
//   ISSUE  | first command driven, held until cmd_ready
//   WAIT   | waiting for store_done (bounded by TIMEOUT)
//   CHECK  | debit: compare fetched balance against the amount
//   ISSUE2 | debit: subtract transaction driven, held until cmd_ready
//   WAIT2  | debit: waiting for the subtract to complete
//   RESP   | rsp_valid pulse
module kv_cmd_sequencer
  import kv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int KEY_WIDTH  = 32,
  parameter int VAL_WIDTH  = 32,
  parameter int H_WIDTH    = 9,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [KEY_WIDTH-1:0] in_key,
  input  logic [VAL_WIDTH-1:0] in_value,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [1:0]           cmd_signal,
  output logic                 cmd_transact_kind,
  output logic [KEY_WIDTH-1:0] cmd_key,
  output logic [VAL_WIDTH-1:0] cmd_value,
  output logic [VAL_WIDTH-1:0] cmd_transact_value,
  output logic [H_WIDTH-1:0]   cmd_hash1,
  output logic [H_WIDTH-1:0]   cmd_hash2,
  input  logic                 store_done,
  input  logic                 store_found,
  input  logic [VAL_WIDTH-1:0] store_updated_value,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_op,
  output logic [KEY_WIDTH-1:0] rsp_key,
  output logic [VAL_WIDTH-1:0] rsp_value,
  output logic [1:0]           rsp_status
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  // ---------------- request FIFO ----------------
  logic [1:0]           fifo_op_q  [FIFO_DEPTH];
  logic [KEY_WIDTH-1:0] fifo_key_q [FIFO_DEPTH];
  logic [VAL_WIDTH-1:0] fifo_val_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 in_ready_q, in_ready_d;
  logic                 push, pop;

  kv_state_e            state_q, state_d;

  assign push = in_valid && in_ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  // pointer/count update; in_ready is registered from the next count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != CW'(FIFO_DEPTH));
  end

  // FIFO control registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate them
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_op_q[wr_ptr_q]  <= in_op;
      fifo_key_q[wr_ptr_q] <= in_key;
      fifo_val_q[wr_ptr_q] <= in_value;
    end
  end

  assign in_ready = in_ready_q;

  // ---------------- hash stage ----------------
  kv_hash_unit #(
    .KEY_WIDTH (KEY_WIDTH),
    .H_WIDTH   (H_WIDTH)
  ) u_hash (
    .clock (clock),
    .reset (reset),
    .load  (pop),
    .key   (fifo_key_q[rd_ptr_q]),
    .h1    (cmd_hash1),
    .h2    (cmd_hash2)
  );

  // ---------------- sequencer ----------------
  logic [1:0]           op_q, op_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [VAL_WIDTH-1:0] amt_q, amt_d;
  logic [VAL_WIDTH-1:0] bal_q, bal_d;
  logic                 found_q, found_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [1:0]           cmd_sig_q, cmd_sig_d;
  logic                 cmd_kind_q, cmd_kind_d;
  logic [KEY_WIDTH-1:0] cmd_key_q, cmd_key_d;
  logic [VAL_WIDTH-1:0] cmd_val_q, cmd_val_d;
  logic [VAL_WIDTH-1:0] cmd_tval_q, cmd_tval_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_op_q, rsp_op_d;
  logic [KEY_WIDTH-1:0] rsp_key_q, rsp_key_d;
  logic [VAL_WIDTH-1:0] rsp_value_q, rsp_value_d;
  logic [1:0]           rsp_status_q, rsp_status_d;
  logic                 resp_go;
  logic [1:0]           resp_status;
  logic [VAL_WIDTH-1:0] resp_value;

  // next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    key_d        = key_q;
    amt_d        = amt_q;
    bal_d        = bal_q;
    found_d      = found_q;
    timer_d      = timer_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_sig_d    = cmd_sig_q;
    cmd_kind_d   = cmd_kind_q;
    cmd_key_d    = cmd_key_q;
    cmd_val_d    = cmd_val_q;
    cmd_tval_d   = cmd_tval_q;
    rsp_valid_d  = 1'b0;
    rsp_op_d     = rsp_op_q;
    rsp_key_d    = rsp_key_q;
    rsp_value_d  = rsp_value_q;
    rsp_status_d = rsp_status_q;
    resp_go      = 1'b0;
    resp_status  = STAT_OK;
    resp_value   = '0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          op_d    = fifo_op_q[rd_ptr_q];
          key_d   = fifo_key_q[rd_ptr_q];
          amt_d   = fifo_val_q[rd_ptr_q];
          state_d = S_HASH;
        end
      end

      S_HASH: begin
        if ((op_q == OP_INSERT) && (key_q == '0)) begin
          resp_go     = 1'b1;
          resp_status = STAT_REJECTED;
        end else begin
          state_d     = S_ISSUE;
          cmd_valid_d = 1'b1;
          cmd_key_d   = key_q;
          cmd_kind_d  = 1'b0;
          cmd_val_d   = '0;
          cmd_tval_d  = '0;
          case (op_q)
            OP_INSERT: begin
              cmd_sig_d = SIG_INSERT;
              cmd_val_d = amt_q;
            end
            OP_CREDIT: begin
              cmd_sig_d  = SIG_TRANSACT;
              cmd_kind_d = 1'b1;
              cmd_tval_d = amt_q;
            end
            default: cmd_sig_d = SIG_SEARCH;  // search, and debit's balance fetch
          endcase
        end
      end

      S_ISSUE, S_ISSUE2: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          timer_d     = TW'(TIMEOUT - 1);
          state_d     = (state_q == S_ISSUE) ? S_WAIT : S_WAIT2;
        end
      end

      S_WAIT: begin
        if (store_done) begin
          if (op_q == OP_DEBIT) begin
            found_d = store_found;
            bal_d   = store_updated_value;
            state_d = S_CHECK;
          end else begin
            resp_go     = 1'b1;
            resp_value  = store_updated_value;
            resp_status = ((op_q != OP_INSERT) && !store_found) ? STAT_NOT_FOUND : STAT_OK;
          end
        end else if (timer_q == '0) begin
          resp_go     = 1'b1;
          resp_status = STAT_REJECTED;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_CHECK: begin
        if (!found_q) begin
          resp_go     = 1'b1;
          resp_status = STAT_NOT_FOUND;
          resp_value  = bal_q;
        end else if (bal_q < amt_q) begin
          resp_go     = 1'b1;
          resp_status = STAT_INSUFFICIENT;
          resp_value  = bal_q;
        end else begin
          state_d     = S_ISSUE2;
          cmd_valid_d = 1'b1;
          cmd_sig_d   = SIG_TRANSACT;
          cmd_kind_d  = 1'b0;
          cmd_val_d   = '0;
          cmd_tval_d  = amt_q;
        end
      end

      S_WAIT2: begin
        if (store_done) begin
          resp_go     = 1'b1;
          resp_status = STAT_OK;
          resp_value  = store_updated_value;
        end else if (timer_q == '0) begin
          resp_go     = 1'b1;
          resp_status = STAT_REJECTED;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (resp_go) begin
      state_d      = S_RESP;
      rsp_valid_d  = 1'b1;
      rsp_op_d     = op_q;
      rsp_key_d    = key_q;
      rsp_value_d  = resp_value;
      rsp_status_d = resp_status;
    end
  end

  // sequencer state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      key_q        <= '0;
      amt_q        <= '0;
      bal_q        <= '0;
      found_q      <= 1'b0;
      timer_q      <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_sig_q    <= '0;
      cmd_kind_q   <= 1'b0;
      cmd_key_q    <= '0;
      cmd_val_q    <= '0;
      cmd_tval_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= '0;
      rsp_key_q    <= '0;
      rsp_value_q  <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      key_q        <= key_d;
      amt_q        <= amt_d;
      bal_q        <= bal_d;
      found_q      <= found_d;
      timer_q      <= timer_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_sig_q    <= cmd_sig_d;
      cmd_kind_q   <= cmd_kind_d;
      cmd_key_q    <= cmd_key_d;
      cmd_val_q    <= cmd_val_d;
      cmd_tval_q   <= cmd_tval_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_key_q    <= rsp_key_d;
      rsp_value_q  <= rsp_value_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign cmd_valid          = cmd_valid_q;
  assign cmd_signal         = cmd_sig_q;
  assign cmd_transact_kind  = cmd_kind_q;
  assign cmd_key            = cmd_key_q;
  assign cmd_value          = cmd_val_q;
  assign cmd_transact_value = cmd_tval_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_op             = rsp_op_q;
  assign rsp_key            = rsp_key_q;
  assign rsp_value          = rsp_value_q;
  assign rsp_status         = rsp_status_q;

endmodule

// File: tb/tb_kv_cmd_sequencer.sv
// Bench for kv_cmd_sequencer: a transaction-level account model predicts
// each store command and each response; a store emulator answers commands.
module tb_kv_cmd_sequencer;

  localparam int KW = 32;
  localparam int VW = 32;
  localparam int HW = 9;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [KW-1:0] in_key;
  logic [VW-1:0] in_value;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_signal;
  logic          cmd_transact_kind;
  logic [KW-1:0] cmd_key;
  logic [VW-1:0] cmd_value;
  logic [VW-1:0] cmd_transact_value;
  logic [HW-1:0] cmd_hash1;
  logic [HW-1:0] cmd_hash2;
  logic          store_done;
  logic          store_found;
  logic [VW-1:0] store_updated_value;
  logic          rsp_valid;
  logic [1:0]    rsp_op;
  logic [KW-1:0] rsp_key;
  logic [VW-1:0] rsp_value;
  logic [1:0]    rsp_status;

  kv_cmd_sequencer #(
    .FIFO_DEPTH (4),
    .KEY_WIDTH  (KW),
    .VAL_WIDTH  (VW),
    .H_WIDTH    (HW),
    .TIMEOUT    (64)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_op               (in_op),
    .in_key              (in_key),
    .in_value            (in_value),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_signal          (cmd_signal),
    .cmd_transact_kind   (cmd_transact_kind),
    .cmd_key             (cmd_key),
    .cmd_value           (cmd_value),
    .cmd_transact_value  (cmd_transact_value),
    .cmd_hash1           (cmd_hash1),
    .cmd_hash2           (cmd_hash2),
    .store_done          (store_done),
    .store_found         (store_found),
    .store_updated_value (store_updated_value),
    .rsp_valid           (rsp_valid),
    .rsp_op              (rsp_op),
    .rsp_key             (rsp_key),
    .rsp_value           (rsp_value),
    .rsp_status          (rsp_status)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    logic [1:0]  status;
    logic [31:0] value;
    bit          chk_val;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [1:0]  sig;
    logic        kind;
    logic [31:0] key;
    logic [31:0] value;
    logic [31:0] tval;
    logic [8:0]  h1;
    logic [8:0]  h2;
  } cmd_t;

  rsp_t        exp_rsp[$];
  cmd_t        exp_cmd[$];
  logic [31:0] mmem [logic [31:0]];   // model's view of account balances
  logic [31:0] smem [logic [31:0]];   // emulated store contents

  bit muted      = 1'b0;   // store swallows commands without completing
  bit hold_ready = 1'b0;
  int store_lat  = 1;
  bit inflight   = 1'b0;

  function automatic logic [8:0] ref_h(input logic [31:0] key, input int mult, input int slots);
    longint p;
    p = (longint'(key) * longint'(mult)) % 64'h1_0000_0000;
    return 9'(((p % 100) * slots) / 100);
  endfunction

  // account-level prediction of the commands and response for one request
  task automatic predict(input logic [1:0] op, input logic [31:0] key,
                         input logic [31:0] val, input int lat);
    rsp_t r;
    cmd_t c;
    r.op = op; r.key = key; r.lat = lat; r.acc = cyc;
    r.chk_val = 1'b1; r.value = '0; r.status = 2'd0;
    c.key = key; c.h1 = ref_h(key, 91, 11); c.h2 = ref_h(key, 45, 22);
    c.value = '0; c.tval = '0; c.kind = 1'b0; c.sig = 2'd0;
    if (op == 2'd1 && key == 0) begin
      r.status = 2'd3; r.chk_val = 1'b0;
    end else begin
      if (op == 2'd1) begin c.sig = 2'd1; c.value = val; end
      if (op == 2'd2) begin c.sig = 2'd2; c.kind = 1'b1; c.tval = val; end
      exp_cmd.push_back(c);
      if (muted) begin
        r.status = 2'd3; r.chk_val = 1'b0;
      end else begin
        case (op)
          2'd0: if (mmem.exists(key)) r.value = mmem[key];
                else begin r.status = 2'd1; r.chk_val = 1'b0; end
          2'd1: begin mmem[key] = val; r.value = val; end
          2'd2: if (mmem.exists(key)) begin mmem[key] = mmem[key] + val; r.value = mmem[key]; end
                else begin r.status = 2'd1; r.chk_val = 1'b0; end
          default: begin
            if (!mmem.exists(key)) begin
              r.status = 2'd1; r.chk_val = 1'b0;
            end else if (mmem[key] < val) begin
              r.status = 2'd2; r.value = mmem[key];
            end else begin
              c.sig = 2'd2; c.kind = 1'b0; c.tval = val;
              exp_cmd.push_back(c);
              mmem[key] = mmem[key] - val;
              r.value = mmem[key];
            end
          end
        endcase
      end
    end
    exp_rsp.push_back(r);
  endtask

  // store emulator: answers commands, checks them against the model, and
  // checks operand stability while a command is stalled
  initial begin : store_emul
    int cd;
    bit pf;
    logic [31:0] pv, k;
    bit stall_prev;
    logic [63:0] sv_a, sv_b;
    cmd_t c;
    cd = 0; stall_prev = 1'b0; pf = 1'b0; pv = '0; sv_a = '0; sv_b = '0;
    store_done = 1'b0; store_found = 1'b0; store_updated_value = '0; cmd_ready = 1'b1;
    forever begin
      @(negedge clock);
      store_done = 1'b0;
      if (reset) begin
        cd = 0; stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("cmd_valid_held", cmd_valid, 1);
          chk("cmd_stable_kv", {cmd_key, cmd_value}, sv_a);
          chk("cmd_stable_rest", {cmd_transact_value, 3'b0, cmd_signal, cmd_transact_kind,
                                  cmd_hash1, cmd_hash2}, sv_b);
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            store_done = 1'b1; store_found = pf; store_updated_value = pv; inflight = 1'b0;
          end
        end
        cmd_ready = !hold_ready;
        if (cmd_valid && cmd_ready) begin
          chk("one_cmd_in_flight", inflight, 0);
          inflight = 1'b1;
          if (exp_cmd.size() == 0) begin
            nvec++; nmis++;
            $display("FAIL unexpected_cmd: got signal %0d key 0x%0h, wanted none", cmd_signal, cmd_key);
          end else begin
            c = exp_cmd.pop_front();
            chk("cmd_signal", cmd_signal, c.sig);
            chk("cmd_kind", cmd_transact_kind, c.kind);
            chk("cmd_key", cmd_key, c.key);
            chk("cmd_value", cmd_value, c.value);
            chk("cmd_tvalue", cmd_transact_value, c.tval);
            chk("cmd_hash1", cmd_hash1, c.h1);
            chk("cmd_hash2", cmd_hash2, c.h2);
          end
          k = cmd_key;
          case (cmd_signal)
            2'd0: begin pf = smem.exists(k); pv = pf ? smem[k] : 32'd0; end
            2'd1: begin pf = smem.exists(k); smem[k] = cmd_value; pv = cmd_value; end
            default: begin
              pf = smem.exists(k);
              if (pf) begin
                smem[k] = cmd_transact_kind ? smem[k] + cmd_transact_value
                                            : smem[k] - cmd_transact_value;
                pv = smem[k];
              end else pv = '0;
            end
          endcase
          if (!muted) cd = store_lat;
        end
        stall_prev = cmd_valid && !cmd_ready;
        sv_a = {cmd_key, cmd_value};
        sv_b = {cmd_transact_value, 3'b0, cmd_signal, cmd_transact_kind, cmd_hash1, cmd_hash2};
      end
    end
  end

  // response checker against the model queue
  initial begin : rsp_check
    rsp_t r;
    forever begin
      @(negedge clock);
      if (!reset && rsp_valid) begin
        inflight = 1'b0;
        if (exp_rsp.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL unexpected_rsp: got key 0x%0h status %0d, wanted none", rsp_key, rsp_status);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_op", rsp_op, r.op);
          chk("rsp_key", rsp_key, r.key);
          chk("rsp_status", rsp_status, r.status);
          if (r.chk_val) chk("rsp_value", rsp_value, r.value);
          if (r.lat >= 0) chk("rsp_latency", 64'(cyc - r.acc), 64'(r.lat));
        end
      end
    end
  end

  // called at a negedge; leaves in_valid high, returns one negedge after acceptance
  task automatic push(input logic [1:0] op, input logic [31:0] key,
                      input logic [31:0] val, input int lat);
    int n;
    in_valid = 1'b1; in_op = op; in_key = key; in_value = val;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    else predict(op, key, val, lat);
    @(negedge clock);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_rsp.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (exp_rsp.size() != 0) begin
      chk("drain_pending_rsp", 64'(exp_rsp.size()), 0);
      exp_rsp.delete();
      exp_cmd.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit saw_cmd;
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_key = '0; in_value = '0;
    repeat (3) @(negedge clock);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_cmd_valid", cmd_valid, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_hash1", cmd_hash1, 0);
    chk("reset_rsp_status", rsp_status, 0);
    chk("reset_rsp_value", rsp_value, 0);
    reset = 1'b0;
    @(negedge clock);

    push(2'd1, 32'd5, 32'd100, 5); drain();
    push(2'd0, 32'd5, 32'd0, 5);   drain();
    chk("lit_key5_hash1", cmd_hash1, 6);
    chk("lit_key5_hash2", cmd_hash2, 5);
    chk("lit_search_value", rsp_value, 100);

    push(2'd1, 32'd7, 32'd100, 5); drain();
    push(2'd3, 32'd7, 32'd30, 8);  drain();
    chk("lit_debit_value", rsp_value, 70);
    chk("lit_debit_status", rsp_status, 0);

    push(2'd3, 32'd7, 32'd200, 6); drain();
    chk("lit_insuff_value", rsp_value, 70);
    chk("lit_insuff_status", rsp_status, 2);

    push(2'd1, 32'd0, 32'd55, 3);  drain();
    chk("lit_reject_status", rsp_status, 3);

    push(2'd2, 32'd7, 32'hFFFF_FFF0, 5); drain();
    chk("lit_credit_wrap", rsp_value, 32'h36);
    push(2'd2, 32'd99, 32'd1, 5);  drain();
    push(2'd0, 32'd1234, 32'd0, 5); drain();
    push(2'd3, 32'd55, 32'd10, 6); drain();
    push(2'd3, 32'd7, 32'h36, 8);  drain();
    chk("lit_debit_exact", rsp_value, 0);

    store_lat = 3;
    push(2'd0, 32'd5, 32'd0, 7);   drain();
    store_lat = 1;

    // backpressure: five back-to-back requests while the store stalls
    hold_ready = 1'b1;
    push(2'd2, 32'd5, 32'd1, -1);
    push(2'd0, 32'd7, 32'd0, -1);
    push(2'd1, 32'd8, 32'd80, -1);
    push(2'd2, 32'd8, 32'd5, -1);
    push(2'd0, 32'd5, 32'd0, -1);
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    repeat (6) @(negedge clock);
    chk("full_in_ready_held", in_ready, 0);
    chk("stalled_cmd_valid", cmd_valid, 1);
    hold_ready = 1'b0;
    drain();

    // store never completes: timeout after 64 WAIT cycles
    muted = 1'b1;
    push(2'd0, 32'd5, 32'd0, 68);  drain();
    chk("lit_timeout_status", rsp_status, 3);
    muted = 1'b0;

    // reset while a command is waiting and another is buffered
    muted = 1'b1;
    push(2'd0, 32'd5, 32'd0, -1);
    push(2'd0, 32'd7, 32'd0, -1);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    exp_rsp.delete();
    exp_cmd.delete();
    inflight = 1'b0;
    @(negedge clock);
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_cmd_valid", cmd_valid, 0);
    reset = 1'b0;
    muted = 1'b0;
    saw_cmd = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (cmd_valid || rsp_valid) saw_cmd = 1'b1;
    end
    chk("postreset_fifo_empty", saw_cmd, 0);

    push(2'd0, 32'd7, 32'd0, 5);   drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
